fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end: the consumer of the pipeline controller's `stall_fetch` and `flush_pipeline` outputs. Generates sequential PCs and issues in-order requests to instruction memory. Buffers returned instructions in a small queue and hands them to decode over a valid/ready handshake. On flush, redirects the PC, empties the queue and silently discards responses still in flight.

## Interface
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `QDEPTH`, 4: fetch queue entries; must be a power of two, ≥2.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_fetch`  in  1  from controller; blocks new memory requests.
- `flush_pipeline`  in  1  from controller; one-cycle flush pulse.
- `redirect_pc`  in  XLEN  target PC, sampled when `flush_pipeline`=1.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  XLEN  request PC.
- `imem_resp_valid`  in  1  response valid; in order, always accepted, at least 1 cycle after acceptance.
- `imem_resp_data`  in  XLEN  instruction word.
- `dec_valid`  out  1  queue head valid.
- `dec_ready`  in  1  decode accepts head.
- `dec_instr`  out  XLEN  head instruction.
- `dec_pc`  out  XLEN  head PC.
- `fq_full`  out  1  queue count == QDEPTH.
- `fq_empty`  out  1  queue count == 0.
- `fetch_err`  out  1  sticky: response received with nothing outstanding.

## Operation
- State:
  - `pc` register.
  - Queue of {pc, instr} with rd/wr pointers and count (`$clog2(QDEPTH)+1` bits).
  - `outstanding` count of accepted, unreturned, non-dropped requests.
  - `drop_cnt` of responses to discard.
  - A PC FIFO parallel to `outstanding` pairs each response with its request address. It is QDEPTH deep.
- Credit rule: `imem_req_valid = !stall_fetch && !flush_pipeline && (outstanding + count < QDEPTH) && (outstanding + drop_cnt < QDEPTH)`. This guarantees every response has a queue slot, so there is no overflow and no resp backpressure.
- `imem_req_addr = pc`. On request handshake: `pc <= pc + 4` (wraps modulo 2^XLEN), `outstanding` +1, push pc into PC FIFO.
- Response handling:
  - If `drop_cnt>0`: decrement `drop_cnt` and discard the response.
  - Else if `outstanding>0`: push {PC FIFO head, data} into queue, pop PC FIFO, `outstanding` −1.
  - Else: set `fetch_err` and discard the response.
- Decode handshake: `dec_valid = !fq_empty && !flush_pipeline`. When `dec_valid && dec_ready`, pop the head.
- Flush cycle:
  - Queue emptied (pointers and count ← 0); PC FIFO emptied; `pc <= redirect_pc`; `outstanding <= 0`.
  - `drop_cnt <= drop_cnt + outstanding`, minus 1 if a response arrives this cycle. That response counts against whichever of `drop_cnt`/`outstanding` the normal priority would select; it is discarded either way.
  - No request and no decode pop occur this cycle.
- Flush has priority over stall, push and pop in the same cycle.
- `stall_fetch` affects requests only. Responses keep landing and decode keeps draining.

## Timing
- Reset values (asynchronous):
  - `pc=RESET_PC`; queue, `outstanding`, `drop_cnt` = 0; `fetch_err=0`.
  - Hence `dec_valid=0`, `fq_empty=1`, `fq_full=0`.
  - `imem_req_valid` may assert the first cycle after `rst` deasserts.
- `imem_req_valid`, `dec_valid`, `dec_instr`, `dec_pc` are combinational from registers plus `stall_fetch`/`flush_pipeline`. They are not combinational from `imem_req_ready` or `dec_ready`.
- Latency: response in cycle M → `dec_valid` in M+1. There is no bypass.
- Simultaneous push and pop on a full queue: allowed; count unchanged.
- Back-to-back requests: one per cycle while credit allows.
- `rst` mid-operation: all state cleared immediately; in-flight memory transactions are the environment's responsibility.

## Test plan
- Reset then free run: `RESET_PC=0x100`, memory 1-cycle latency, `dec_ready=1`.
  - Requests 0x100, 0x104, 0x108…, one per cycle.
  - `dec_pc` sequence matches, 2 cycles after each request.
- Backpressure: `dec_ready=0`, QDEPTH=4.
  - Exactly 4 requests issue, then `imem_req_valid=0` and `fq_full=1`.
  - Raising `dec_ready` resumes issue one pop later.
- Flush with 2 in flight: memory latency 3, `flush_pipeline` pulse with `redirect_pc=0x200`.
  - The next 2 responses are dropped.
  - The first `dec_pc` seen is 0x200.
  - The queue is empty in the cycle after the flush.
- Response coincident with flush: the response is dropped, `drop_cnt` ends correct, and no stale instruction reaches decode.
- `stall_fetch` held 5 cycles with 2 outstanding: no new requests, both responses delivered to decode, and issue resumes at the next sequential PC.
- Spurious `imem_resp_valid` with nothing outstanding: `fetch_err`=1 and stays set until `rst`; the queue is unchanged.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus the
// decode handoff. master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory
// requests, response queue to decode, and flush with in-flight response discard.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_fetch,
  input  logic            flush_pipeline,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus,
  output logic            fq_full,
  output logic            fq_empty,
  output logic            fetch_err
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] pc_reg;
  logic [AW-1:0]   q_rd_reg, q_wr_reg, pf_rd_reg, pf_wr_reg;
  logic [CW-1:0]   q_cnt_reg, out_reg, drop_reg;
  logic            err_reg;

  logic [XLEN-1:0] q_pc_mem    [QDEPTH];
  logic [XLEN-1:0] q_instr_mem [QDEPTH];
  logic [XLEN-1:0] pf_mem      [QDEPTH];

  logic [CW:0] credit_q, credit_d;
  logic        req_valid, req_fire;
  logic        resp_drop, resp_take, resp_err;
  logic        q_push, q_pop, dec_valid;

  // Reserving a queue slot per outstanding request means responses never stall.
  assign credit_q  = {1'b0, out_reg} + {1'b0, q_cnt_reg};
  assign credit_d  = {1'b0, out_reg} + {1'b0, drop_reg};
  assign req_valid = !stall_fetch && !flush_pipeline
                     && (credit_q < DEPTH_W) && (credit_d < DEPTH_W);
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign resp_drop = bus.imem_resp_valid && (drop_reg != '0);
  assign resp_take = bus.imem_resp_valid && (drop_reg == '0) && (out_reg != '0);
  assign resp_err  = bus.imem_resp_valid && (drop_reg == '0) && (out_reg == '0);

  assign fq_empty  = (q_cnt_reg == '0);
  assign fq_full   = (q_cnt_reg == CW'(QDEPTH));
  assign dec_valid = !fq_empty && !flush_pipeline;
  assign q_push    = resp_take && !flush_pipeline;
  assign q_pop     = dec_valid && bus.dec_ready;
  assign fetch_err = err_reg;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_reg;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_instr      = q_instr_mem[q_rd_reg];
  assign bus.dec_pc         = q_pc_mem[q_rd_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      q_rd_reg  <= '0;
      q_wr_reg  <= '0;
      pf_rd_reg <= '0;
      pf_wr_reg <= '0;
      q_cnt_reg <= '0;
      out_reg   <= '0;
      drop_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (resp_err) err_reg <= 1'b1;
      if (flush_pipeline) begin
        pc_reg    <= redirect_pc;
        q_rd_reg  <= '0;
        q_wr_reg  <= '0;
        pf_rd_reg <= '0;
        pf_wr_reg <= '0;
        q_cnt_reg <= '0;
        out_reg   <= '0;
        // Every in-flight request becomes a drop; a response landing now is already consumed.
        drop_reg  <= drop_reg + out_reg - CW'(resp_drop || resp_take);
      end else begin
        if (req_fire) begin
          pc_reg    <= pc_reg + XLEN'(4);
          pf_wr_reg <= pf_wr_reg + AW'(1);
        end
        if (q_push) begin
          q_wr_reg  <= q_wr_reg + AW'(1);
          pf_rd_reg <= pf_rd_reg + AW'(1);
        end
        if (q_pop) q_rd_reg <= q_rd_reg + AW'(1);
        q_cnt_reg <= q_cnt_reg + CW'(q_push) - CW'(q_pop);
        out_reg   <= out_reg + CW'(req_fire) - CW'(resp_take);
        drop_reg  <= drop_reg - CW'(resp_drop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by pointers and counts.
  always_ff @(posedge clk) begin
    if (req_fire) pf_mem[pf_wr_reg] <= pc_reg;
    if (q_push) begin
      q_pc_mem[q_wr_reg]    <= pf_mem[pf_rd_reg];
      q_instr_mem[q_wr_reg] <= bus.imem_resp_data;
    end
  end
endmodule
